// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared fetch-stage constants and state encoding
package npc_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_OUT  = 2'd3
    } fetch_state_e;

    localparam logic [63:0] RESET_PC  = 64'h8000_0000;
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;

endpackage

// File: rtl/ifu_pc_gen.sv
// rtl/ifu_pc_gen.sv - program counter register with redirect mux and +4 step
module ifu_pc_gen #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            advance_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_next_o,
    output logic            next_misaligned_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // A redirect always wins over sequential advance; the adder wraps naturally.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = redirect_pc_i;
        end else if (advance_i) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o              = pc_q;
    assign pc_next_o         = pc_d;
    assign next_misaligned_o = |pc_d[1:0];

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: one outstanding read, registered handoff to decode
module ifu_fetch #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = npc_pkg::RESET_PC[XLEN-1:0]
) (
    input  logic            clock,
    input  logic            reset,
    output logic            io_ar_valid,
    input  logic            io_ar_ready,
    output logic [XLEN-1:0] io_ar_addr,
    input  logic            io_r_valid,
    output logic            io_r_ready,
    input  logic [ILEN-1:0] io_r_data,
    input  logic [1:0]      io_r_resp,
    output logic            io_out_valid,
    input  logic            io_out_ready,
    output logic [ILEN-1:0] io_out_inst,
    output logic [XLEN-1:0] io_out_pc,
    output logic            io_out_fault,
    input  logic            io_redirect_valid,
    input  logic [XLEN-1:0] io_redirect_pc,
    input  logic            io_halt
);

    import npc_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] ar_addr_q, ar_addr_d;
    logic [ILEN-1:0] out_inst_q, out_inst_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic            out_fault_q, out_fault_d;
    logic            discard_q, discard_d;
    logic            halted_q, halted_d;

    logic            advance;
    logic            go_ar;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            next_misaligned;

    ifu_pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk_i             (clock),
        .rst_i             (reset),
        .redirect_valid_i  (io_redirect_valid),
        .redirect_pc_i     (io_redirect_pc),
        .advance_i         (advance),
        .pc_o              (pc),
        .pc_next_o         (pc_next),
        .next_misaligned_o (next_misaligned)
    );

    always_comb begin
        state_d     = state_q;
        ar_addr_d   = ar_addr_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        out_fault_d = out_fault_q;
        discard_d   = discard_q;
        halted_d    = halted_q | io_halt;
        advance     = 1'b0;
        go_ar       = 1'b0;

        case (state_q)
            S_IDLE: begin
                go_ar = !halted_d;
            end
            // The request in flight cannot be withdrawn, so a redirect only marks its data stale.
            S_AR: begin
                if (io_redirect_valid) begin
                    discard_d = 1'b1;
                end
                if (io_ar_ready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (io_r_valid) begin
                    if (discard_q || io_redirect_valid) begin
                        discard_d = 1'b0;
                        go_ar     = 1'b1;
                    end else begin
                        out_inst_d  = io_r_data;
                        out_pc_d    = pc;
                        out_fault_d = (io_r_resp != RESP_OKAY);
                        state_d     = S_OUT;
                    end
                end else if (io_redirect_valid) begin
                    discard_d = 1'b1;
                end
            end
            S_OUT: begin
                if (io_redirect_valid) begin
                    go_ar = 1'b1;
                end else if (io_out_ready) begin
                    advance = 1'b1;
                    go_ar   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Entry into S_AR: halted units park, misaligned targets skip the bus and fault.
        if (go_ar) begin
            if (halted_d) begin
                state_d = S_IDLE;
            end else if (next_misaligned) begin
                out_inst_d  = ILEN'(NOP_INST);
                out_pc_d    = pc_next;
                out_fault_d = 1'b1;
                state_d     = S_OUT;
            end else begin
                ar_addr_d = pc_next;
                state_d   = S_AR;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ar_addr_q   <= RESET_PC;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
            out_fault_q <= 1'b0;
            discard_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ar_addr_q   <= ar_addr_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            out_fault_q <= out_fault_d;
            discard_q   <= discard_d;
            halted_q    <= halted_d;
        end
    end

    assign io_ar_valid  = (state_q == S_AR);
    assign io_ar_addr   = ar_addr_q;
    assign io_r_ready   = (state_q == S_R);
    assign io_out_valid = (state_q == S_OUT);
    assign io_out_inst  = out_inst_q;
    assign io_out_pc    = out_pc_q;
    assign io_out_fault = out_fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - randomized fetch-unit bench against a transaction-level pc/memory model
module tb_ifu_fetch;

    localparam logic [63:0] RPC = 64'h8000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_ar_valid, io_ar_ready;
    logic [63:0] io_ar_addr;
    logic        io_r_valid, io_r_ready;
    logic [31:0] io_r_data;
    logic [1:0]  io_r_resp;
    logic        io_out_valid, io_out_ready;
    logic [31:0] io_out_inst;
    logic [63:0] io_out_pc;
    logic        io_out_fault;
    logic        io_redirect_valid;
    logic [63:0] io_redirect_pc;
    logic        io_halt;

    always #5 clock = ~clock;

    ifu_fetch dut (
        .clock             (clock),
        .reset             (reset),
        .io_ar_valid       (io_ar_valid),
        .io_ar_ready       (io_ar_ready),
        .io_ar_addr        (io_ar_addr),
        .io_r_valid        (io_r_valid),
        .io_r_ready        (io_r_ready),
        .io_r_data         (io_r_data),
        .io_r_resp         (io_r_resp),
        .io_out_valid      (io_out_valid),
        .io_out_ready      (io_out_ready),
        .io_out_inst       (io_out_inst),
        .io_out_pc         (io_out_pc),
        .io_out_fault      (io_out_fault),
        .io_redirect_valid (io_redirect_valid),
        .io_redirect_pc    (io_redirect_pc),
        .io_halt           (io_halt)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // memory contents and response policy
    bit fixed_mode = 0;
    bit force_err = 0;
    int ar_pct = 100;
    int r_pct = 100;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (fixed_mode) return 32'h0000_0413;
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [1:0] resp_of(input logic [63:0] a);
        if (force_err) return 2'b10;
        if (fixed_mode) return 2'b00;
        return (a[5:2] == 4'd7) ? 2'b10 : 2'b00;
    endfunction

    // model state
    logic [63:0] mpc;
    logic [63:0] pend_q[$];
    logic [63:0] dpc_q[$];
    logic [31:0] dinst_q[$];
    int          dcyc_q[$];
    bit          prev_arv, prev_ar_stall, prev_out_hold, prev_fault, halt_seen;
    logic [63:0] prev_ara, prev_opc;
    logic [31:0] prev_inst;
    int          cyc, first_ov, ar_rises, n_ar_fire, n_deliv;

    task automatic model_clear();
        mpc = RPC;
        pend_q.delete();
        dpc_q.delete();
        dinst_q.delete();
        dcyc_q.delete();
        prev_arv = 0; prev_ar_stall = 0; prev_out_hold = 0; prev_fault = 0;
        prev_ara = '0; prev_opc = '0; prev_inst = '0;
        halt_seen = 0;
        cyc = 0; first_ov = -1; ar_rises = 0; n_ar_fire = 0; n_deliv = 0;
    endtask

    // Called at a negedge: drive memory, check outputs against the model, advance one cycle.
    task automatic step();
        logic        misal;
        logic [31:0] e_inst;
        logic        e_fault;
        io_ar_ready = ($urandom_range(99) < ar_pct);
        if (pend_q.size() > 0 && $urandom_range(99) < r_pct) begin
            io_r_valid = 1'b1;
            io_r_data  = mem_word(pend_q[0]);
            io_r_resp  = resp_of(pend_q[0]);
        end else begin
            io_r_valid = 1'b0;
            io_r_data  = $urandom;
            io_r_resp  = 2'($urandom);
        end

        if (io_ar_valid && !prev_arv) begin
            ar_rises++;
            chk("ar_addr_at_issue", io_ar_addr, mpc);
        end
        if (halt_seen) chk("ar_quiet_after_halt", io_ar_valid && !prev_arv, 1'b0);
        if (prev_ar_stall) begin
            chk("ar_valid_held", io_ar_valid, 1'b1);
            chk("ar_addr_held", io_ar_addr, prev_ara);
        end
        if (prev_out_hold) begin
            chk("out_valid_held", io_out_valid, 1'b1);
            chk("out_pc_held", io_out_pc, prev_opc);
            chk("out_inst_held", io_out_inst, prev_inst);
            chk("out_fault_held", io_out_fault, prev_fault);
        end
        if (io_out_valid && first_ov < 0) first_ov = cyc;

        if (io_r_valid && io_r_ready) void'(pend_q.pop_front());
        if (io_ar_valid && io_ar_ready) begin
            pend_q.push_back(io_ar_addr);
            n_ar_fire++;
        end
        if (io_out_valid && io_out_ready) begin
            misal   = |mpc[1:0];
            e_inst  = misal ? 32'h0000_0013 : mem_word(mpc);
            e_fault = misal ? 1'b1 : (resp_of(mpc) != 2'b00);
            chk("deliver_pc", io_out_pc, mpc);
            chk("deliver_inst", io_out_inst, e_inst);
            chk("deliver_fault", io_out_fault, e_fault);
            n_deliv++;
            dpc_q.push_back(io_out_pc);
            dinst_q.push_back(io_out_inst);
            dcyc_q.push_back(cyc);
            mpc = mpc + 64'd4;
        end
        if (io_redirect_valid) mpc = io_redirect_pc;

        prev_arv      = io_ar_valid;
        prev_ara      = io_ar_addr;
        prev_ar_stall = io_ar_valid && !io_ar_ready;
        prev_out_hold = io_out_valid && !io_out_ready && !io_redirect_valid;
        prev_opc      = io_out_pc;
        prev_inst     = io_out_inst;
        prev_fault    = io_out_fault;
        if (io_halt) halt_seen = 1;
        cyc++;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        io_ar_ready = 1'b0;
        io_r_valid = 1'b0;
        io_redirect_valid = 1'b0;
        io_halt = 1'b0;
        #1;
        chk("rst_ar_valid", io_ar_valid, 1'b0);
        chk("rst_r_ready", io_r_ready, 1'b0);
        chk("rst_out_valid", io_out_valid, 1'b0);
        chk("rst_out_inst", io_out_inst, 32'h0);
        chk("rst_out_pc", io_out_pc, 64'h0);
        chk("rst_out_fault", io_out_fault, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0: return io_r_ready;
            1: return io_out_valid;
            default: return io_ar_valid && !prev_arv;
        endcase
    endfunction

    task automatic wait_cond(input int sel, input string name);
        int n = 0;
        while (!cond(sel) && n < 60) begin
            step();
            n++;
        end
        chk(name, cond(sel), 1'b1);
    endtask

    task automatic redirect_step(input logic [63:0] target);
        io_redirect_valid = 1'b1;
        io_redirect_pc = target;
        step();
        io_redirect_valid = 1'b0;
    endtask

    int base, rises0;

    initial begin
        reset = 1'b1;
        io_out_ready = 1'b0;
        io_redirect_pc = '0;
        io_r_data = '0;
        io_r_resp = '0;
        model_clear();
        @(negedge clock);

        // 1: zero-wait memory, steady stream
        fixed_mode = 1;
        ar_pct = 100; r_pct = 100;
        io_out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 12; i++) step();
        chk("t1_first_out_cycle", first_ov, 3);
        chk("t1_count", dpc_q.size() >= 3, 1'b1);
        if (dpc_q.size() >= 3) begin
            chk("t1_pc0", dpc_q[0], 64'h8000_0000);
            chk("t1_pc1", dpc_q[1], 64'h8000_0004);
            chk("t1_pc2", dpc_q[2], 64'h8000_0008);
            chk("t1_inst0", dinst_q[0], 32'h0000_0413);
            chk("t1_gap01", dcyc_q[1] - dcyc_q[0], 3);
            chk("t1_gap12", dcyc_q[2] - dcyc_q[1], 3);
        end

        // 2: ar_ready low for 5 cycles (reset lands mid-transaction)
        fixed_mode = 0;
        ar_pct = 0;
        io_out_ready = 1'b0;
        do_reset();
        wait_cond(2, "t2_ar_issue");
        for (int i = 0; i < 5; i++) begin
            chk("t2_ar_valid_stable", io_ar_valid, 1'b1);
            chk("t2_ar_addr_stable", io_ar_addr, 64'h8000_0000);
            step();
        end
        ar_pct = 100;
        for (int i = 0; i < 8; i++) step();
        chk("t2_single_handshake", n_ar_fire, 1);
        chk("t2_out_valid", io_out_valid, 1'b1);

        // 3: redirect while waiting for read data
        io_out_ready = 1'b1;
        r_pct = 0;
        wait_cond(0, "t3_in_r");
        base = n_deliv;
        redirect_step(64'h8000_0100);
        r_pct = 100;
        wait_cond(2, "t3_reissue");
        chk("t3_no_out", n_deliv - base, 0);
        chk("t3_next_ar", io_ar_addr, 64'h8000_0100);

        // 4: redirect in S_OUT with out_ready high
        base = n_deliv;
        wait_cond(1, "t4_out");
        redirect_step(64'h8000_0200);
        wait_cond(2, "t4_reissue");
        chk("t4_consumed_once", n_deliv - base, 1);
        chk("t4_consumed_pc", dpc_q[dpc_q.size()-1], 64'h8000_0100);
        chk("t4_next_ar", io_ar_addr, 64'h8000_0200);

        // 5: misaligned redirect target
        wait_cond(1, "t5_out");
        redirect_step(64'h8000_0102);
        rises0 = ar_rises;
        io_out_ready = 1'b0;
        wait_cond(1, "t5_nop_out");
        chk("t5_no_ar", ar_rises - rises0, 0);
        chk("t5_inst", io_out_inst, 32'h0000_0013);
        chk("t5_fault", io_out_fault, 1'b1);
        chk("t5_pc", io_out_pc, 64'h8000_0102);
        io_out_ready = 1'b1;
        redirect_step(RPC);

        // 6: error response, then halt while in S_R
        force_err = 1;
        io_out_ready = 1'b0;
        do_reset();
        wait_cond(1, "t6_out");
        chk("t6_fault", io_out_fault, 1'b1);
        chk("t6_inst", io_out_inst, 32'hDA5A_0000);
        io_out_ready = 1'b1;
        step();
        force_err = 0;
        r_pct = 0;
        wait_cond(0, "t6_in_r");
        io_halt = 1'b1;
        step();
        io_halt = 1'b0;
        r_pct = 100;
        base = n_deliv;
        wait_cond(1, "t6_halt_deliver");
        chk("t6_halt_pc", io_out_pc, 64'h8000_0004);
        step();
        chk("t6_delivered", n_deliv - base, 1);
        for (int i = 0; i < 20; i++) begin
            chk("t6_ar_idle", io_ar_valid, 1'b0);
            step();
        end

        // random traffic with redirects, misaligned targets and one mid-run reset
        do_reset();
        for (int seg = 0; seg < 2; seg++) begin
            for (int i = 0; i < 1500; i++) begin
                if (i % 50 == 0) begin
                    ar_pct = $urandom_range(20, 100);
                    r_pct = $urandom_range(20, 100);
                end
                io_out_ready = ($urandom_range(99) < 60);
                io_redirect_valid = ($urandom_range(99) < 4);
                io_redirect_pc = RPC + 64'({$urandom_range(0, 63), 2'b00});
                if ($urandom_range(9) == 0) io_redirect_pc[1:0] = 2'($urandom_range(1, 3));
                step();
                io_redirect_valid = 1'b0;
            end
            chk("rand_progress", n_deliv > 100, 1'b1);
            if (seg == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
